// File: rtl/spell_mem_wb_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spell_mem_wb_sram_pkg
// Description : Shared constants for the Spell memory unit's SRAM port and
//               its Wishbone responder model.
// Revision    : 1.0 - initial release
// ============================================================================
package spell_mem_wb_sram_pkg;

    // Wait-state counter width; WAIT_STATES must stay in 0..SPELL_SRAM_MAX_WAIT.
    localparam int unsigned SPELL_SRAM_WAIT_W   = 4;
    localparam int unsigned SPELL_SRAM_MAX_WAIT = 15;

    // Wishbone word-address layout: bit 6 selects data space,
    // bits 5:0 are the word index within that space.
    localparam int unsigned SPELL_WB_DATA_SPACE_BIT = 6;
    localparam int unsigned SPELL_WB_WORD_IDX_W     = 6;

    // Memory-type defines sitting next to the address layout.
    localparam logic [1:0] SPELL_MEM_TYPE_SRAM  = 2'd0;
    localparam logic [1:0] SPELL_MEM_TYPE_FLASH = 2'd1;

endpackage
`default_nettype wire

// File: rtl/spell_mem_wb_sram_array.sv
`default_nettype none
// ============================================================================
// Module      : spell_mem_wb_sram_array
// Description : 2**ADDR_WIDTH x 32 synchronous array, per-byte write enable,
//               registered read port with enable, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
module spell_mem_wb_sram_array #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic [3:0]            we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    // One independent byte-wide bank per lane keeps each lane's write enable
    // local to its own storage.
    for (genvar n = 0; n < 4; n++) begin : g_lane
        logic [7:0] mem_q [DEPTH];
        logic [7:0] rd_q;

        // Lane write, and read register that only updates on a read access.
        always_ff @(posedge clock) begin
            if (we_i[n]) begin
                mem_q[addr_i] <= wdata_i[8*n +: 8];
            end
            if (re_i) begin
                rd_q <= mem_q[addr_i];
            end
        end

        assign rdata_o[8*n +: 8] = rd_q;
    end

endmodule
`default_nettype wire

// File: rtl/spell_mem_wb_sram.sv
`default_nettype none
// ============================================================================
// Module      : spell_mem_wb_sram
// Description : Wishbone classic-cycle responder modelling the OpenRAM macro
//               behind the Spell SRAM port. Fixed wait states, one-cycle ack.
// Revision    : 1.0 - initial release
// ============================================================================
module spell_mem_wb_sram
    import spell_mem_wb_sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 1   // 0..SPELL_SRAM_MAX_WAIT
) (
    input  logic                  clock,
    input  logic                  reset,        // synchronous, active-low
    input  logic                  sram_cyc_i,
    input  logic                  sram_stb_i,
    input  logic                  sram_we_i,
    input  logic [3:0]            sram_sel_i,
    input  logic [ADDR_WIDTH-1:0] sram_addr_i,
    input  logic [31:0]           sram_dat_i,
    output logic [31:0]           sram_dat_o,
    output logic                  sram_ack_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic [SPELL_SRAM_WAIT_W-1:0] CNT_LOAD =
        (WAIT_STATES == 0) ? '0 : SPELL_SRAM_WAIT_W'(WAIT_STATES - 1);

    logic [1:0]                   state_q;
    logic [SPELL_SRAM_WAIT_W-1:0] cnt_q;
    logic                         we_q;
    logic [3:0]                   sel_q;
    logic [ADDR_WIDTH-1:0]        addr_q;
    logic [31:0]                  dat_q;
    logic                         ack_q;
    logic                         rd_valid_q;   // a read has completed since reset

    logic                         req;
    logic                         ack_d;
    logic                         acc_is_we;
    logic [3:0]                   acc_we;
    logic                         acc_re;
    logic [ADDR_WIDTH-1:0]        acc_addr;
    logic [31:0]                  acc_wdata;
    logic [31:0]                  arr_rdata;

    // Decide whether this edge enters ACK and build the array access. With zero
    // wait states the access happens on the sampling edge, so the live bus is
    // used; otherwise the copy latched in IDLE is used.
    always_comb begin
        req       = sram_cyc_i & sram_stb_i;
        ack_d     = 1'b0;
        acc_is_we = we_q;
        acc_addr  = addr_q;
        acc_wdata = dat_q;
        acc_we    = 4'b0000;
        acc_re    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ack_d     = reset & req & (WAIT_STATES == 0);
                acc_is_we = sram_we_i;
                acc_addr  = sram_addr_i;
                acc_wdata = sram_dat_i;
            end
            ST_WAIT: ack_d = reset & req & (cnt_q == '0);
            default: ack_d = 1'b0;
        endcase
        if (ack_d) begin
            if (acc_is_we) begin
                acc_we = (state_q == ST_IDLE) ? sram_sel_i : sel_q;
            end else begin
                acc_re = 1'b1;
            end
        end
    end

    // Transaction FSM: request latch, wait-state countdown, single-cycle ack.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            sel_q      <= 4'b0000;
            addr_q     <= '0;
            dat_q      <= '0;
            ack_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            if (acc_re) begin
                rd_valid_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        we_q   <= sram_we_i;
                        sel_q  <= sram_sel_i;
                        addr_q <= sram_addr_i;
                        dat_q  <= sram_dat_i;
                        if (WAIT_STATES == 0) begin
                            state_q <= ST_ACK;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        state_q <= ST_IDLE;       // abort: no write, no ack
                    end else if (cnt_q == '0) begin
                        state_q <= ST_ACK;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_ACK:  state_q <= ST_IDLE;      // always pass through IDLE
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    spell_mem_wb_sram_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clock   (clock),
        .we_i    (acc_we),
        .re_i    (acc_re),
        .addr_i  (acc_addr),
        .wdata_i (acc_wdata),
        .rdata_o (arr_rdata)
    );

    // The array read register holds the last read word; it is masked to zero
    // until the first read after reset.
    assign sram_dat_o = rd_valid_q ? arr_rdata : 32'h0;
    assign sram_ack_o = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_spell_mem_wb_sram.sv
`default_nettype none
// ============================================================================
// Module      : tb_spell_mem_wb_sram
// Description : Directed, table-driven bench for spell_mem_wb_sram using three
//               instances (WAIT_STATES = 0, 1, 3) on one clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spell_mem_wb_sram;

    logic        clk;
    logic        rst_n;
    logic        cyc  [3];
    logic        stb  [3];
    logic        we   [3];
    logic [3:0]  sel  [3];
    logic [7:0]  adr  [3];
    logic [31:0] wdat [3];
    logic [31:0] rdat [3];
    logic        ack  [3];

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] last_rd [3];

    // index 0: WAIT_STATES=0, index 1: WAIT_STATES=1, index 2: WAIT_STATES=3
    spell_mem_wb_sram #(.ADDR_WIDTH(8), .WAIT_STATES(0)) u_ws0 (
        .clock(clk), .reset(rst_n), .sram_cyc_i(cyc[0]), .sram_stb_i(stb[0]),
        .sram_we_i(we[0]), .sram_sel_i(sel[0]), .sram_addr_i(adr[0]),
        .sram_dat_i(wdat[0]), .sram_dat_o(rdat[0]), .sram_ack_o(ack[0]));
    spell_mem_wb_sram #(.ADDR_WIDTH(8), .WAIT_STATES(1)) u_ws1 (
        .clock(clk), .reset(rst_n), .sram_cyc_i(cyc[1]), .sram_stb_i(stb[1]),
        .sram_we_i(we[1]), .sram_sel_i(sel[1]), .sram_addr_i(adr[1]),
        .sram_dat_i(wdat[1]), .sram_dat_o(rdat[1]), .sram_ack_o(ack[1]));
    spell_mem_wb_sram #(.ADDR_WIDTH(8), .WAIT_STATES(3)) u_ws3 (
        .clock(clk), .reset(rst_n), .sram_cyc_i(cyc[2]), .sram_stb_i(stb[2]),
        .sram_we_i(we[2]), .sram_sel_i(sel[2]), .sram_addr_i(adr[2]),
        .sram_dat_i(wdat[2]), .sram_dat_o(rdat[2]), .sram_ack_o(ack[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          d;
        bit          wr;
        logic [3:0]  sl;
        logic [7:0]  ad;
        logic [31:0] wd;
        logic [31:0] exp;   // expected read word (reads only)
        int          lat;   // expected ack cycle, strobe raised in cycle 0
    } vec_t;

    vec_t vt [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input bit wr, input logic [3:0] sl,
                         input logic [7:0] ad, input logic [31:0] wd);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = wr;
        sel[d] = sl;   adr[d] = ad;   wdat[d] = wd;
    endtask

    task automatic release_bus(input int d);
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    endtask

    // One complete transfer: measure ack latency, check data, check ack drops.
    task automatic run_xfer(input int idx, input vec_t v);
        int          lat;
        logic [31:0] got;
        lat = 0;
        got = 'x;
        @(posedge clk); #1;
        drive(v.d, v.wr, v.sl, v.ad, v.wd);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (ack[v.d]) begin
                lat = k;
                got = rdat[v.d];
                break;
            end
        end
        release_bus(v.d);
        chk($sformatf("vec%0d_latency", idx), lat, v.lat);
        if (v.wr) begin
            chk($sformatf("vec%0d_dat_hold", idx), got, last_rd[v.d]);
        end else begin
            chk($sformatf("vec%0d_rdata", idx), got, v.exp);
            last_rd[v.d] = v.exp;
        end
        @(posedge clk); #1;
        chk($sformatf("vec%0d_ack_drop", idx), 32'(ack[v.d]), 32'h0);
    endtask

    initial begin
        int   lat;
        logic pat [7];

        for (int i = 0; i < 3; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
            sel[i] = 4'h0; adr[i] = 8'h00; wdat[i] = 32'h0;
            last_rd[i] = 32'h0;
        end
        rst_n = 1'b0;

        vt[0]  = '{1, 1'b1, 4'hF, 8'h05, 32'hDEADBEEF, 32'h0,        2};
        vt[1]  = '{1, 1'b0, 4'hF, 8'h05, 32'h0,        32'hDEADBEEF, 2};
        vt[2]  = '{1, 1'b1, 4'hF, 8'h40, 32'h11223344, 32'h0,        2};
        vt[3]  = '{1, 1'b1, 4'h2, 8'h40, 32'hAABBCCDD, 32'h0,        2};
        vt[4]  = '{1, 1'b1, 4'h0, 8'h40, 32'hAABBCCDD, 32'h0,        2};
        vt[5]  = '{1, 1'b0, 4'h0, 8'h40, 32'h0,        32'h1122CC44, 2};
        vt[6]  = '{1, 1'b1, 4'hF, 8'h01, 32'h01010101, 32'h0,        2};
        vt[7]  = '{1, 1'b1, 4'hF, 8'h02, 32'h02020202, 32'h0,        2};
        vt[8]  = '{1, 1'b1, 4'hF, 8'h03, 32'h00000000, 32'h0,        2};
        vt[9]  = '{1, 1'b1, 4'h9, 8'h03, 32'h12345678, 32'h0,        2};
        vt[10] = '{1, 1'b0, 4'h0, 8'h03, 32'h0,        32'h12000078, 2};
        vt[11] = '{1, 1'b1, 4'hF, 8'hFF, 32'hFFFF0000, 32'h0,        2};
        vt[12] = '{1, 1'b1, 4'hF, 8'h00, 32'h0BADF00D, 32'h0,        2};
        vt[13] = '{1, 1'b0, 4'hF, 8'hFF, 32'h0,        32'hFFFF0000, 2};
        vt[14] = '{1, 1'b0, 4'hF, 8'h00, 32'h0,        32'h0BADF00D, 2};
        vt[15] = '{2, 1'b1, 4'hF, 8'h10, 32'h5A5A5A5A, 32'h0,        4};
        vt[16] = '{2, 1'b0, 4'hF, 8'h10, 32'h0,        32'h5A5A5A5A, 4};
        vt[17] = '{0, 1'b1, 4'hF, 8'h20, 32'hCAFEF00D, 32'h0,        1};
        vt[18] = '{0, 1'b0, 4'hF, 8'h20, 32'h0,        32'hCAFEF00D, 1};

        // Reset held 3 cycles with a live strobe: no ack, dat_o zero.
        drive(1, 1'b1, 4'hF, 8'h7F, 32'h77777777);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rst%0d_ack", i), 32'(ack[1]), 32'h0);
            chk($sformatf("rst%0d_dat", i), rdat[1], 32'h0);
        end
        rst_n = 1'b1;   // strobe still high: this is cycle 0 of the first request
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (ack[1]) begin
                lat = k;
                break;
            end
        end
        release_bus(1);
        chk("post_reset_latency", lat, 2);

        // Table-driven transfers.
        for (int i = 0; i < 19; i++) begin
            run_xfer(i, vt[i]);
        end

        // Held strobe across two reads; address change during WAIT is ignored.
        @(posedge clk); #1;
        drive(1, 1'b0, 4'hF, 8'h01, 32'h0);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            pat[c] = ack[1];
            if (c == 1) adr[1] = 8'h02;
            if (c == 2) chk("held_rd1", rdat[1], 32'h01010101);
            if (c == 5) begin
                chk("held_rd2", rdat[1], 32'h02020202);
                release_bus(1);
            end
        end
        chk("held_ack_c1", 32'(pat[1]), 32'h0);
        chk("held_ack_c2", 32'(pat[2]), 32'h1);
        chk("held_ack_c3", 32'(pat[3]), 32'h0);
        chk("held_ack_c4", 32'(pat[4]), 32'h0);
        chk("held_ack_c5", 32'(pat[5]), 32'h1);
        chk("held_ack_c6", 32'(pat[6]), 32'h0);
        last_rd[1] = 32'h02020202;

        // Abort on WAIT_STATES=3: strobe dropped after one cycle.
        @(posedge clk); #1;
        drive(2, 1'b1, 4'hF, 8'h10, 32'hFFFFFFFF);
        @(posedge clk); #1;
        release_bus(2);
        lat = 0;
        for (int k = 2; k <= 9; k++) begin
            @(posedge clk); #1;
            if (ack[2] && lat == 0) lat = k;
        end
        chk("abort_no_ack", lat, 0);
        run_xfer(100, '{2, 1'b0, 4'hF, 8'h10, 32'h0, 32'h5A5A5A5A, 4});

        // WAIT_STATES=0: reset at the edge that would perform the write.
        @(posedge clk); #1;
        drive(0, 1'b1, 4'hF, 8'h20, 32'h11111111);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("ws0_rst_ack", 32'(ack[0]), 32'h0);
        chk("ws0_rst_dat", rdat[0], 32'h0);
        rst_n = 1'b1;
        release_bus(0);
        for (int i = 0; i < 3; i++) last_rd[i] = 32'h0;
        @(posedge clk); #1;
        chk("ws0_rst_ack2", 32'(ack[0]), 32'h0);
        run_xfer(101, '{0, 1'b0, 4'hF, 8'h20, 32'h0, 32'hCAFEF00D, 1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
